mux_nway_rr: RTL and testbench

- Parametrised, clocked successor to the combinational Mux/Mux4Way16/Mux8Way16 family.
- Merges N input channels of WIDTH bits onto one registered output using valid/ready handshakes.
- Selects among requesting channels by round-robin or fixed-priority arbitration; also outputs the index of the selected channel.
- Sits between multiple producers (ALU results, memory-mapped sources) and a single consumer bus.

---
 rtl/mux_nway_rr_pkg.sv | 12 +
 rtl/rr_pick.sv | 40 ++++
 rtl/mux_nway_rr.sv | 91 +++++++++
 tb/tb_mux_nway_rr.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_nway_rr_pkg.sv
// Shared defaults for the N-way registered channel merger and its arbiter.
// Arbitration mode constants select round-robin or fixed lowest-index priority.
package mux_nway_rr_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N     = 8;
    localparam int DEF_SELW  = 3;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: first requester found scanning from ptr (round-robin)
// or from index 0 (fixed priority), returned as one-hot grant plus binary index.
module rr_pick
    import mux_nway_rr_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int SELW = DEF_SELW
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx,
    output logic            any
);

    int w_start;
    int w_j;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any     = 1'b0;
        w_j     = 0;
        w_start = (mode == 1'(ARB_RR)) ? int'(ptr) : 0;
        // Wrap explicitly at N so non-power-of-two channel counts scan correctly.
        for (int k = 0; k < N; k++) begin
            w_j = w_start + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!any && req[w_j]) begin
                grant[w_j] = 1'b1;
                idx        = SELW'(w_j);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nway_rr.sv
// Merges N valid/ready channels onto one registered output word plus source index.
// Output register reloads in the same cycle it is consumed, so throughput is one word per cycle.
module mux_nway_rr
    import mux_nway_rr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SELW  = DEF_SELW,
    parameter int RR    = ARB_RR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic MODE = (RR != ARB_FIXED);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_sel;
    logic [SELW-1:0]  r_ptr;

    logic             w_load_ok;
    logic             w_take;
    logic             w_any;
    logic [N-1:0]     w_grant;
    logic [SELW-1:0]  w_idx;
    logic [SELW-1:0]  w_ptr_next;
    logic [WIDTH-1:0] w_sel_data;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req   (in_valid),
        .ptr   (r_ptr),
        .mode  (MODE),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    // Valid/ready: a channel transfers on a rising edge where its in_valid and
    // in_ready are both high; in_ready may look at in_valid, never the reverse.
    assign w_load_ok = !r_out_valid || out_ready;
    assign w_take    = w_load_ok && !reset;
    assign in_ready  = w_take ? w_grant : '0;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_sel_data = w_sel_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_idx == SELW'(N - 1)) ? '0 : w_idx + SELW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load_ok) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_idx;
                // Fixed-priority mode never moves the pointer.
                if (MODE) begin
                    r_ptr <= w_ptr_next;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_nway_rr.sv
// Bench for mux_nway_rr: three instances (RR N=8, RR N=5, fixed N=8) checked every
// cycle against a queue-free behavioural model, plus directed literal expectations.
module tb_mux_nway_rr;

    logic clk = 1'b0;
    logic rst;

    logic [127:0] d    [3];
    logic [7:0]   v    [3];
    logic         ordy [3];

    logic [7:0]  rdy0, rdy2;
    logic [4:0]  rdy1;
    logic [15:0] od0, od1, od2;
    logic [2:0]  os0, os1, os2;
    logic        ov0, ov1, ov2;

    logic [7:0]  rdy_a [3];
    logic [15:0] od_a  [3];
    logic [2:0]  os_a  [3];
    logic        ov_a  [3];

    int  n_of  [3] = '{8, 5, 8};
    bit  rr_of [3] = '{1'b1, 1'b1, 1'b0};

    bit          m_valid [3];
    logic [15:0] m_data  [3];
    int          m_sel   [3];
    int          m_ptr   [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mux_nway_rr #(.WIDTH(16), .N(8), .SELW(3), .RR(1)) u_rr8 (
        .clock(clk), .reset(rst), .in_data(d[0]), .in_valid(v[0]), .in_ready(rdy0),
        .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(ordy[0])
    );

    mux_nway_rr #(.WIDTH(16), .N(5), .SELW(3), .RR(1)) u_rr5 (
        .clock(clk), .reset(rst), .in_data(d[1][79:0]), .in_valid(v[1][4:0]), .in_ready(rdy1),
        .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(ordy[1])
    );

    mux_nway_rr #(.WIDTH(16), .N(8), .SELW(3), .RR(0)) u_fix8 (
        .clock(clk), .reset(rst), .in_data(d[2]), .in_valid(v[2]), .in_ready(rdy2),
        .out_data(od2), .out_sel(os2), .out_valid(ov2), .out_ready(ordy[2])
    );

    always_comb begin
        rdy_a[0] = rdy0;
        rdy_a[1] = {3'b000, rdy1};
        rdy_a[2] = rdy2;
        od_a[0]  = od0;
        od_a[1]  = od1;
        od_a[2]  = od2;
        os_a[0]  = os0;
        os_a[1]  = os1;
        os_a[2]  = os2;
        ov_a[0]  = ov0;
        ov_a[1]  = ov1;
        ov_a[2]  = ov2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First requester walking the ring from the start point; -1 if nobody asks.
    function automatic int pick(logic [7:0] req, int ptr, int n, bit rr);
        int start;
        int j;
        start = rr ? ptr : 0;
        for (int k = 0; k < n; k++) begin
            j = (start + k) % n;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Compare process: outputs against model state, in_ready against model grant, then advance the model.
    always @(negedge clk) begin
        if (chk_en) begin
            #1;
            for (int k = 0; k < 3; k++) begin
                int         g;
                bit         lok;
                logic [7:0] er;
                chk($sformatf("out_valid[%0d]", k), 32'(ov_a[k]), 32'(m_valid[k]));
                chk($sformatf("out_data[%0d]", k), 32'(od_a[k]), 32'(m_data[k]));
                chk($sformatf("out_sel[%0d]", k), 32'(os_a[k]), m_sel[k]);
                lok = !m_valid[k] || ordy[k];
                g   = pick(v[k], m_ptr[k], n_of[k], rr_of[k]);
                er  = (lok && g >= 0 && !rst) ? 8'(1 << g) : 8'h00;
                chk($sformatf("in_ready[%0d]", k), 32'(rdy_a[k]), 32'(er));
                if (rst) begin
                    m_valid[k] = 1'b0;
                    m_data[k]  = '0;
                    m_sel[k]   = 0;
                    m_ptr[k]   = 0;
                end else if (lok) begin
                    if (g >= 0) begin
                        m_valid[k] = 1'b1;
                        m_data[k]  = d[k][g*16 +: 16];
                        m_sel[k]   = g;
                        if (rr_of[k]) m_ptr[k] = (g + 1) % n_of[k];
                    end else begin
                        m_valid[k] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int e0 [3] = '{2, 6, 2};
        int e1 [3] = '{0, 3, 0};

        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            m_sel[k]   = 0;
            m_ptr[k]   = 0;
        end

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v[k]    = 8'hFF;
            ordy[k] = 1'b1;
            d[k]    = '0;
            for (int i = 0; i < 8; i++) d[k][i*16 +: 16] = 16'(i);
        end

        // Reset held two cycles with every channel requesting.
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("reset in_ready", 32'(rdy0), 32'h0);
        chk("reset out_valid", 32'(ov0), 32'h0);
        chk("reset out_data", 32'(od0), 32'h0);
        chk("reset out_sel", 32'(os0), 32'h0);
        rst = 1'b0;
        #1;
        chk("first grant", 32'(rdy0), 32'h01);

        // Round-robin sweep, all valid, no bubbles.
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("sweep out_valid", 32'(ov0), 32'h1);
            chk("sweep out_sel", 32'(os0), 32'(i % 8));
            chk("sweep out_data", 32'(od0), 32'(i % 8));
        end

        // Sparse requests: park ptr at 7 (N=8) and 0 via 4->0 wrap (N=5).
        v[0] = 8'h40; v[1] = 8'h10; v[2] = 8'h40;
        cyc();
        chk("park sel n8", 32'(os0), 32'h6);
        chk("park sel n5", 32'(os1), 32'h4);
        v[0] = 8'h44; v[1] = 8'h09; v[2] = 8'h44;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("sparse sel n8", 32'(os0), 32'(e0[i]));
            chk("sparse sel n5", 32'(os1), 32'(e1[i]));
        end

        // Backpressure with 16'h0003 held.
        v[0] = 8'h08; v[1] = 8'h08; v[2] = 8'h08;
        cyc();
        chk("bp load", 32'(od0), 32'h3);
        ordy[0] = 1'b0;
        v[0] = 8'hFF;
        #1;
        chk("bp in_ready", 32'(rdy0), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("bp hold data", 32'(od0), 32'h3);
            chk("bp hold sel", 32'(os0), 32'h3);
            chk("bp hold valid", 32'(ov0), 32'h1);
            chk("bp hold in_ready", 32'(rdy0), 32'h0);
        end
        ordy[0] = 1'b1;
        #1;
        chk("bp release in_ready", 32'(rdy0), 32'h10);
        cyc();
        chk("bp release sel", 32'(os0), 32'h4);
        chk("bp release data", 32'(od0), 32'h4);

        // Fixed priority on the RR=0 instance.
        v[0] = 8'h8A; v[1] = 8'h0A; v[2] = 8'h8A;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fixed sel 1", 32'(os2), 32'h1);
        end
        v[2] = 8'h88;
        cyc();
        chk("fixed sel 3", 32'(os2), 32'h3);
        v[2] = 8'h80;
        cyc();
        chk("fixed sel 7", 32'(os2), 32'h7);

        // Reset while 16'h0005 is held.
        v[0] = 8'h20;
        cyc();
        chk("pre-reset data", 32'(od0), 32'h5);
        ordy[0] = 1'b0;
        v[0] = 8'hFF;
        cyc();
        rst = 1'b1;
        cyc();
        chk("mid reset out_valid", 32'(ov0), 32'h0);
        chk("mid reset out_data", 32'(od0), 32'h0);
        chk("mid reset out_sel", 32'(os0), 32'h0);
        rst = 1'b0;
        ordy[0] = 1'b1;
        cyc();
        chk("resume from 0", 32'(os0), 32'h0);

        // Random traffic, data, backpressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                v[k]    = 8'($urandom_range(0, 255));
                d[k]    = {$urandom, $urandom, $urandom, $urandom};
                ordy[k] = ($urandom_range(0, 9) < 7);
            end
            if (c % 500 < 40) begin
                for (int k = 0; k < 3; k++) begin
                    v[k]    = 8'hFF;
                    ordy[k] = 1'b1;
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
